// File: rtl/mem_load_scheduler_if.sv
// mem_load_scheduler_if: pass control, configuration and reader/compute handshake bundle
interface mem_load_scheduler_if;
    logic       start;
    logic [7:0] img_base;
    logic [7:0] img_step;
    logic [7:0] filt_base;
    logic [7:0] filt_step;
    logic [7:0] z_cfg;
    logic       rd_start;
    logic [7:0] rd_x;
    logic [7:0] rd_y;
    logic [7:0] rd_z;
    logic       rd_done;
    logic       cmp_start;
    logic       cmp_done;
    logic [7:0] tile_idx;
    logic [7:0] group_idx;
    logic       busy;
    logic       done;
    modport master (
        input  start, img_base, img_step, filt_base, filt_step, z_cfg, rd_done, cmp_done,
        output rd_start, rd_x, rd_y, rd_z, cmp_start, tile_idx, group_idx, busy, done
    );
    modport slave (
        output start, img_base, img_step, filt_base, filt_step, z_cfg, rd_done, cmp_done,
        input  rd_start, rd_x, rd_y, rd_z, cmp_start, tile_idx, group_idx, busy, done
    );
endinterface

// File: rtl/mem_load_scheduler.sv
// mem_load_scheduler: sequences reader loads and compute runs over every tile of every filter group
module mem_load_scheduler #(
    parameter int NUM_TILES  = 4,
    parameter int NUM_GROUPS = 2
) (
    input logic                  clk,
    input logic                  rst,
    mem_load_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_WAIT, CMP_REQ, CMP_WAIT, ADVANCE, FINISH} state_t;
    state_t     state, state_nxt;
    logic [7:0] img_base_r, img_step_r, filt_step_r, z_r;
    logic [7:0] x_acc, y_acc, tile_r, group_r;
    logic       last_tile, last_group;
    assign last_tile  = tile_r == 8'(NUM_TILES - 1);
    assign last_group = group_r == 8'(NUM_GROUPS - 1);
    // state register; reset aborts any pass in progress
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    // next state from the current state and the reader/compute handshakes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = bus.start ? LOAD_REQ : IDLE;
            LOAD_REQ:  state_nxt = LOAD_WAIT;
            LOAD_WAIT: state_nxt = bus.rd_done ? CMP_REQ : LOAD_WAIT;
            CMP_REQ:   state_nxt = CMP_WAIT;
            CMP_WAIT:  state_nxt = bus.cmp_done ? ADVANCE : CMP_WAIT;
            ADVANCE:   state_nxt = (last_tile && last_group) ? FINISH : LOAD_REQ;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
    // configuration latch and running address accumulators (equal to base + idx*step mod 256)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            img_base_r  <= '0;
            img_step_r  <= '0;
            filt_step_r <= '0;
            z_r         <= '0;
            x_acc       <= '0;
            y_acc       <= '0;
            tile_r      <= '0;
            group_r     <= '0;
        end else if (state == IDLE && bus.start) begin
            img_base_r  <= bus.img_base;
            img_step_r  <= bus.img_step;
            filt_step_r <= bus.filt_step;
            z_r         <= bus.z_cfg;
            x_acc       <= bus.filt_base;
            y_acc       <= bus.img_base;
            tile_r      <= '0;
            group_r     <= '0;
        end else if (state == ADVANCE && !last_tile) begin
            tile_r <= tile_r + 8'd1;
            y_acc  <= y_acc + img_step_r;
        end else if (state == ADVANCE && !last_group) begin
            tile_r  <= '0;
            group_r <= group_r + 8'd1;
            y_acc   <= img_base_r;
            x_acc   <= x_acc + filt_step_r;
        end
    end
    assign bus.rd_start  = state == LOAD_REQ;
    assign bus.cmp_start = state == CMP_REQ;
    assign bus.done      = state == FINISH;
    assign bus.busy      = state != IDLE;
    assign bus.rd_x      = x_acc;
    assign bus.rd_y      = y_acc;
    assign bus.rd_z      = z_r;
    assign bus.tile_idx  = tile_r;
    assign bus.group_idx = group_r;
endmodule

// File: tb/tb_mem_load_scheduler.sv
// tb_mem_load_scheduler: directed checks of the convolution pass sequencer
module tb_mem_load_scheduler;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    mem_load_scheduler_if ifc ();
    mem_load_scheduler_if ifs ();
    mem_load_scheduler dut (.clk(clk), .rst(rst), .bus(ifc));
    mem_load_scheduler #(.NUM_TILES(1), .NUM_GROUPS(1)) dut1 (.clk(clk), .rst(rst), .bus(ifs));

    int checks = 0, passes = 0;
    int cyc = 0, lat = 3, rd_cnt = -1, cmp_cnt = -1;
    bit resp_en = 1;
    int n_ld = 0, n_cmp = 0, n_done = 0, t_done = 0, viol = 0, t_go = 0;
    int s_rd = -1, s_cmp = -1, s_done = -1, s_nld = 0, s_ncmp = 0;
    logic [7:0] ld_x [64];
    logic [7:0] ld_y [64];
    logic [7:0] ld_z [64];
    int ld_t [64];

    always @(posedge clk) cyc++;

    // reader/compute model: done pulse lat cycles after each start
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            rd_cnt = -1;
            cmp_cnt = -1;
        end else if (resp_en) begin
            ifc.rd_done = rd_cnt == 0;
            ifc.cmp_done = cmp_cnt == 0;
            if (rd_cnt >= 0) rd_cnt--;
            if (cmp_cnt >= 0) cmp_cnt--;
            if (ifc.rd_start) rd_cnt = lat;
            if (ifc.cmp_start) cmp_cnt = lat;
        end
    end

    // observe loads, computes, done pulses and pulse-overlap/stability violations
    always @(negedge clk) begin
        if (ifc.rd_start && n_ld < 64) begin
            ld_x[n_ld] = ifc.rd_x;
            ld_y[n_ld] = ifc.rd_y;
            ld_z[n_ld] = ifc.rd_z;
            ld_t[n_ld] = cyc;
            n_ld++;
        end
        if (ifc.cmp_start) begin
            n_cmp++;
            if (n_ld > 0 && {ifc.rd_x, ifc.rd_y, ifc.rd_z} !== {ld_x[n_ld-1], ld_y[n_ld-1], ld_z[n_ld-1]}) viol++;
        end
        if (ifc.done) begin
            n_done++;
            t_done = cyc;
        end
        if ((ifc.done && ifc.rd_start) || (ifc.rd_start && ifc.cmp_start)) viol++;
        if (ifs.rd_start) begin
            s_nld++;
            if (s_rd < 0) s_rd = cyc;
        end
        if (ifs.cmp_start) begin
            s_ncmp++;
            if (s_cmp < 0) s_cmp = cyc;
        end
        if (ifs.done && s_done < 0) s_done = cyc;
    end

    task automatic clr();
        n_ld = 0;
        n_cmp = 0;
        n_done = 0;
    endtask

    task automatic go(input logic [7:0] ib, ist, fb, fst, z);
        @(posedge clk); #1;
        t_go = cyc;
        {ifc.img_base, ifc.img_step, ifc.filt_base, ifc.filt_step, ifc.z_cfg} = {ib, ist, fb, fst, z};
        ifc.start = 1;
        @(posedge clk); #1;
        ifc.start = 0;
        {ifc.img_base, ifc.img_step, ifc.filt_base, ifc.filt_step, ifc.z_cfg} = {5{8'hA5}};
    endtask

    task automatic wait_done(input int lim, input string nm);
        int n0 = n_done;
        int k = 0;
        while (n_done == n0 && k < lim) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (n_done == n0) $display("FAIL %s_timeout: no done within %0d cycles", nm, lim);
        else passes++;
    endtask

    task automatic test_reset();
        #1 rst = 0;
        #2;
        checks++;
        if ({ifc.rd_start, ifc.cmp_start, ifc.done, ifc.busy, ifc.rd_x, ifc.rd_y, ifc.rd_z, ifc.tile_idx, ifc.group_idx} !== 44'd0)
            $display("FAIL reset_outputs: got %h expected 0", {ifc.rd_start, ifc.cmp_start, ifc.done, ifc.busy, ifc.rd_x, ifc.rd_y, ifc.rd_z, ifc.tile_idx, ifc.group_idx});
        else passes++;
        checks++;
        if ({ifs.busy, ifs.rd_start, ifs.done} !== 3'b000) $display("FAIL reset_single: got %b expected 000", {ifs.busy, ifs.rd_start, ifs.done});
        else passes++;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ifc.busy, ifc.rd_start} !== 2'b00) $display("FAIL idle_no_start: got %b expected 00", {ifc.busy, ifc.rd_start});
        else passes++;
    endtask

    task automatic test_default();
        clr();
        lat = 3;
        go(8'h10, 8'h20, 8'h80, 8'h40, 8'h07);
        checks++;
        if (ifc.busy !== 1'b1) $display("FAIL busy_after_start: got %b expected 1", ifc.busy);
        else passes++;
        wait_done(300, "default");
        repeat (5) @(posedge clk);
        checks++;
        if ({n_ld, n_cmp, n_done} !== {32'd8, 32'd8, 32'd1}) $display("FAIL default_counts: got ld=%0d cmp=%0d done=%0d expected 8 8 1", n_ld, n_cmp, n_done);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ex, ey;
            ex = 8'h80 + 8'(i / 4) * 8'h40;
            ey = 8'h10 + 8'(i % 4) * 8'h20;
            checks++;
            if ({ld_x[i], ld_y[i], ld_z[i]} !== {ex, ey, 8'h07})
                $display("FAIL default_load%0d: got %h expected %h", i, {ld_x[i], ld_y[i], ld_z[i]}, {ex, ey, 8'h07});
            else passes++;
        end
    endtask

    task automatic test_wrap();
        clr();
        go(8'hF0, 8'h20, 8'h00, 8'h01, 8'h00);
        wait_done(300, "wrap");
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ex, ey;
            ex = 8'(i / 4);
            ey = 8'hF0 + 8'(i % 4) * 8'h20;
            checks++;
            if ({ld_x[i], ld_y[i]} !== {ex, ey}) $display("FAIL wrap_load%0d: got %h expected %h", i, {ld_x[i], ld_y[i]}, {ex, ey});
            else passes++;
        end
    endtask

    task automatic test_min_length();
        resp_en = 0;
        ifc.rd_done = 1;
        ifc.cmp_done = 1;
        clr();
        go(8'h00, 8'h01, 8'h00, 8'h01, 8'h00);
        wait_done(100, "min_length");
        checks++;
        if (ld_t[0] !== t_go + 1) $display("FAIL min_first_load: got cycle %0d expected %0d", ld_t[0], t_go + 1);
        else passes++;
        checks++;
        if (t_done !== t_go + 41) $display("FAIL min_pass_length: got cycle %0d expected %0d", t_done, t_go + 41);
        else passes++;
        ifc.rd_done = 0;
        ifc.cmp_done = 0;
        resp_en = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_spurious();
        resp_en = 0;
        clr();
        go(8'h10, 8'h20, 8'h80, 8'h40, 8'h07);
        @(posedge clk); #1;
        ifc.cmp_done = 1;
        @(posedge clk); #1;
        ifc.cmp_done = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({n_ld, n_cmp} !== {32'd1, 32'd0} || ifc.busy !== 1'b1) $display("FAIL spurious_cmp_done: got ld=%0d cmp=%0d busy=%b expected 1 0 1", n_ld, n_cmp, ifc.busy);
        else passes++;
        ifc.rd_done = 1;
        @(posedge clk); #1;
        ifc.rd_done = 0;
        @(posedge clk); #1;
        ifc.rd_done = 1;
        @(posedge clk); #1;
        ifc.rd_done = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({n_ld, n_cmp} !== {32'd1, 32'd1} || ifc.tile_idx !== 8'd0) $display("FAIL spurious_rd_done: got ld=%0d cmp=%0d tile=%0d expected 1 1 0", n_ld, n_cmp, ifc.tile_idx);
        else passes++;
        ifc.cmp_done = 1;
        @(posedge clk); #1;
        ifc.cmp_done = 0;
        resp_en = 1;
        wait_done(300, "spurious");
        checks++;
        if ({n_ld, n_cmp} !== {32'd8, 32'd8}) $display("FAIL spurious_counts: got ld=%0d cmp=%0d expected 8 8", n_ld, n_cmp);
        else passes++;
    endtask

    task automatic test_start_held();
        int t1, k;
        clr();
        @(posedge clk); #1;
        {ifc.img_base, ifc.img_step, ifc.filt_base, ifc.filt_step, ifc.z_cfg} = {8'h10, 8'h20, 8'h80, 8'h40, 8'h07};
        ifc.start = 1;
        wait_done(300, "held_first");
        t1 = t_done;
        @(posedge clk); #1;
        ifc.start = 0;
        wait_done(300, "held_second");
        k = 0;
        for (int i = 0; i < n_ld; i++) if (ld_t[i] < t1) k++;
        checks++;
        if (k !== 8) $display("FAIL held_first_pass_loads: got %0d expected 8", k);
        else passes++;
        checks++;
        if (ld_t[8] !== t1 + 2) $display("FAIL held_restart_cycle: got %0d expected %0d", ld_t[8], t1 + 2);
        else passes++;
        checks++;
        if ({n_ld, n_done} !== {32'd16, 32'd2}) $display("FAIL held_totals: got ld=%0d done=%0d expected 16 2", n_ld, n_done);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        clr();
        go(8'h10, 8'h20, 8'h80, 8'h40, 8'h07);
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (ifc.cmp_start && ifc.tile_idx == 8'd2) hit = 1;
        end
        checks++;
        if (!hit) $display("FAIL mid_reach_tile2: got none expected cmp_start at tile 2");
        else passes++;
        @(posedge clk); #3;
        rst = 0;
        #1;
        checks++;
        if ({ifc.rd_start, ifc.cmp_start, ifc.done, ifc.busy, ifc.rd_x, ifc.rd_y, ifc.rd_z, ifc.tile_idx, ifc.group_idx} !== 44'd0)
            $display("FAIL mid_async_reset: got %h expected 0", {ifc.rd_start, ifc.cmp_start, ifc.done, ifc.busy, ifc.rd_x, ifc.rd_y, ifc.rd_z, ifc.tile_idx, ifc.group_idx});
        else passes++;
        @(posedge clk); #1;
        rst = 1;
        clr();
        go(8'h33, 8'h01, 8'h44, 8'h02, 8'h09);
        checks++;
        if ({ifc.tile_idx, ifc.group_idx, ifc.rd_x, ifc.rd_y, ifc.rd_z} !== {8'd0, 8'd0, 8'h44, 8'h33, 8'h09})
            $display("FAIL mid_restart: got %h expected %h", {ifc.tile_idx, ifc.group_idx, ifc.rd_x, ifc.rd_y, ifc.rd_z}, {8'd0, 8'd0, 8'h44, 8'h33, 8'h09});
        else passes++;
        wait_done(300, "mid_restart");
        checks++;
        if (n_ld !== 8) $display("FAIL mid_restart_loads: got %0d expected 8", n_ld);
        else passes++;
    endtask

    task automatic test_single();
        int t0;
        s_rd = -1;
        s_cmp = -1;
        s_done = -1;
        s_nld = 0;
        s_ncmp = 0;
        @(posedge clk); #1;
        t0 = cyc;
        ifs.start = 1;
        @(posedge clk); #1;
        ifs.start = 0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({s_rd, s_cmp, s_done} !== {t0 + 1, t0 + 3, t0 + 6}) $display("FAIL single_timing: got rd=%0d cmp=%0d done=%0d expected %0d %0d %0d", s_rd, s_cmp, s_done, t0 + 1, t0 + 3, t0 + 6);
        else passes++;
        checks++;
        if ({s_nld, s_ncmp} !== {32'd1, 32'd1}) $display("FAIL single_counts: got ld=%0d cmp=%0d expected 1 1", s_nld, s_ncmp);
        else passes++;
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) $display("FAIL pulse_overlap_or_unstable: got %0d expected 0", viol);
        else passes++;
    endtask

    initial begin
        ifc.start = 0;
        {ifc.img_base, ifc.img_step, ifc.filt_base, ifc.filt_step, ifc.z_cfg} = '0;
        ifc.rd_done = 0;
        ifc.cmp_done = 0;
        ifs.start = 0;
        {ifs.img_base, ifs.img_step, ifs.filt_base, ifs.filt_step, ifs.z_cfg} = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        ifs.rd_done = 1;
        ifs.cmp_done = 1;
        test_reset();
        test_default();
        test_wrap();
        test_min_length();
        test_spurious();
        test_start_held();
        test_reset_mid();
        test_single();
        test_protocol();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
